spsram_arbiter: RTL and testbench
=================================

Name: spsram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-port SRAM macro (32-bit data, 32 words, i_cen/i_wen/i_oen control).
- Each requester issues single-word read or write commands over a valid/ready handshake.
- The block serialises the commands onto the one SRAM port, drives registered SRAM controls, and routes read data back to the requester that issued the read, tagged with a one-cycle rvalid.
- Sits between two masters (e.g. DMA and CPU-side logic) and the SRAM.

Parameters:
DW, 32, data width of SRAM and requester data buses
AW, 5, address width (2**AW words)
RD_LAT, 1, cycles from the SRAM sampling edge to valid data on i_sram_data (>=1)

Ports:
i_clk  input  1  clock, all logic on rising edge
i_rst  input  1  synchronous reset, active-high
i_req0_valid  input  1  requester 0 command valid
o_req0_ready  output  1  requester 0 command accepted this cycle
i_req0_we  input  1  1=write, 0=read
i_req0_addr  input  AW  command address
i_req0_wdata  input  DW  write data
o_req0_rvalid  output  1  read data valid pulse for requester 0
o_req0_rdata  output  DW  read data for requester 0
i_req1_valid, o_req1_ready, i_req1_we, i_req1_addr, i_req1_wdata, o_req1_rvalid, o_req1_rdata: as requester 0, same widths
o_sram_cen  output  1  SRAM chip enable (registered)
o_sram_wen  output  1  SRAM write enable (registered)
o_sram_oen  output  1  SRAM output enable (registered)
o_sram_addr  output  AW  SRAM address (registered)
o_sram_data  output  DW  SRAM write data (registered)
i_sram_data  input  DW  SRAM read data

Behaviour:
- Reset (i_rst high at a rising edge):
  - o_sram_cen/wen/oen = 0; o_sram_addr = 0; o_sram_data = 0.
  - Both rvalid = 0; both rdata = 0.
  - Priority pointer = requester 0; read-tag pipeline cleared.
- Reset mid-operation discards all in-flight reads: no rvalid is issued for them.
- Arbitration is combinational each cycle; at most one ready is high.
  - Only one valid high: that requester gets ready.
  - Both valid high: the requester indicated by the priority pointer gets ready.
  - Neither valid high: no ready.
  - ready never depends on ready; ready is low during reset.
- Pointer update: after each accept, the pointer moves to the other requester. With no accept, the pointer holds.
- Requesters hold valid, we, addr and wdata stable until ready.
- Accept at edge E0 (valid & ready):
  - Write: o_sram_cen=1, o_sram_wen=1, o_sram_oen=0, addr/data loaded.
  - Read: o_sram_cen=1, o_sram_wen=0, o_sram_oen=1, addr loaded; o_sram_data holds its previous value.
- No accept at an edge: cen=wen=oen=0 at that edge; addr/data hold.
- SRAM samples the command at E1.
- Read return:
  - A tag {valid, requester id} shifts through a (1+RD_LAT)-stage pipeline.
  - At edge E(1+RD_LAT), i_sram_data is registered into the owning requester's rdata, and that rvalid is high for exactly one cycle.
  - The other requester's rdata and rvalid are unchanged.
  - RD_LAT=1: rvalid is high in the cycle after E2, i.e. 2 cycles after accept.
- Throughput is one command per cycle, fully pipelined. Read returns are in issue order, with no backpressure on the read-return path.
- Ordering: commands reach the SRAM in accept order, so a read accepted after a write to the same address returns the new data.
- Both requesters may have reads in flight at once; return routing is by tag only.
- Address wrap: none. AW bits are passed as-is and all 2**AW words are addressable.

Test Plan:
1. Reset, then req0 writes addr i with data i for i=0..31 (valid held continuously). Required: ready0 high every cycle; 32 consecutive cen=1/wen=1 cycles; o_sram_addr = 0..31.
2. req1 reads addr 0..31 back-to-back. Required: rvalid1 pulses on 32 consecutive cycles starting 2 cycles after the first accept; rdata1 = 0..31; rvalid0 never high.
3. Both valid continuously from reset, req0 writing 0xA000_0000+i to addr i and req1 writing 0xB000_0000+i to addr 16+i. Required: grants alternate 0,1,0,1…, with req0 first; no lost or duplicate commands.
4. Same cycle: req0 writes 0x1234_5678 to addr 7, req1 reads addr 7. Requester 0 has priority after reset, so the write is accepted first and the read next. Required: rdata1 = 0x1234_5678.
5. Interleaved reads: req0 reads addr 3, req1 reads addr 4, alternating over 8 cycles (SRAM preloaded with addr-as-data). Required: every rvalid0 carries 3, every rvalid1 carries 4, and pulses arrive in issue order.
6. Assert i_rst for 1 cycle while 2 reads are in flight. Required: no rvalid for them; SRAM controls 0 after the reset edge; next contested grant goes to req0.

Source files
------------

// File: rtl/spsram_arbiter.sv
// spsram_arbiter: two-requester round-robin front end for a single-port SRAM.
// Commands are serialised one per cycle onto registered SRAM controls.
// A {valid, id} tag travels alongside each read so that the returning data
// can be steered back to the requester that issued it.
module spsram_arbiter #(
    parameter int DW     = 32,
    parameter int AW     = 5,
    parameter int RD_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,

    input  logic          i_req0_valid,
    output logic          o_req0_ready,
    input  logic          i_req0_we,
    input  logic [AW-1:0] i_req0_addr,
    input  logic [DW-1:0] i_req0_wdata,
    output logic          o_req0_rvalid,
    output logic [DW-1:0] o_req0_rdata,

    input  logic          i_req1_valid,
    output logic          o_req1_ready,
    input  logic          i_req1_we,
    input  logic [AW-1:0] i_req1_addr,
    input  logic [DW-1:0] i_req1_wdata,
    output logic          o_req1_rvalid,
    output logic [DW-1:0] o_req1_rdata,

    output logic          o_sram_cen,
    output logic          o_sram_wen,
    output logic          o_sram_oen,
    output logic [AW-1:0] o_sram_addr,
    output logic [DW-1:0] o_sram_data,
    input  logic [DW-1:0] i_sram_data
);

    // Priority pointer: 0 favours requester 0 when both are asking.
    logic          r_ptr;

    // Registered SRAM interface.
    logic          r_sram_cen;
    logic          r_sram_wen;
    logic          r_sram_oen;
    logic [AW-1:0] r_sram_addr;
    logic [DW-1:0] r_sram_data;

    // Read-tag pipeline; the last stage lines up with valid SRAM read data.
    logic [RD_LAT:0] r_tag_v;
    logic [RD_LAT:0] r_tag_id;

    // Registered read-return outputs.
    logic          r_req0_rvalid;
    logic [DW-1:0] r_req0_rdata;
    logic          r_req1_rvalid;
    logic [DW-1:0] r_req1_rdata;

    // Grant and selected command.
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_acc;
    logic          w_sel;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // Pick at most one winner; the pointer only breaks ties.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (i_rst) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else if (i_req0_valid && i_req1_valid) begin
            w_gnt0 = ~r_ptr;
            w_gnt1 = r_ptr;
        end else begin
            w_gnt0 = i_req0_valid;
            w_gnt1 = i_req1_valid;
        end
    end

    // Steer the winning requester's command fields onto the shared path.
    always_comb begin
        w_acc   = w_gnt0 | w_gnt1;
        w_sel   = w_gnt1;
        w_we    = 1'b0;
        w_addr  = {AW{1'b0}};
        w_wdata = {DW{1'b0}};
        if (w_gnt1) begin
            w_we    = i_req1_we;
            w_addr  = i_req1_addr;
            w_wdata = i_req1_wdata;
        end else begin
            w_we    = i_req0_we;
            w_addr  = i_req0_addr;
            w_wdata = i_req0_wdata;
        end
    end

    // Hand priority to the other requester after every accepted command.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (w_acc) begin
            r_ptr <= ~w_sel;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    // Launch the accepted command onto the SRAM port; idle cycles drop the strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sram_cen  <= 1'b0;
            r_sram_wen  <= 1'b0;
            r_sram_oen  <= 1'b0;
            r_sram_addr <= {AW{1'b0}};
            r_sram_data <= {DW{1'b0}};
        end else if (w_acc) begin
            r_sram_cen  <= 1'b1;
            r_sram_wen  <= w_we;
            r_sram_oen  <= ~w_we;
            r_sram_addr <= w_addr;
            // Reads leave the write-data bus untouched.
            if (w_we) begin
                r_sram_data <= w_wdata;
            end else begin
                r_sram_data <= r_sram_data;
            end
        end else begin
            r_sram_cen  <= 1'b0;
            r_sram_wen  <= 1'b0;
            r_sram_oen  <= 1'b0;
            r_sram_addr <= r_sram_addr;
            r_sram_data <= r_sram_data;
        end
    end

    // Shift the read tag so it arrives together with the SRAM read data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tag_v  <= {(RD_LAT+1){1'b0}};
            r_tag_id <= {(RD_LAT+1){1'b0}};
        end else begin
            r_tag_v[0]  <= w_acc & ~w_we;
            r_tag_id[0] <= w_sel;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    // Capture returning data for its owner only; the other side holds.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req0_rvalid <= 1'b0;
            r_req0_rdata  <= {DW{1'b0}};
            r_req1_rvalid <= 1'b0;
            r_req1_rdata  <= {DW{1'b0}};
        end else begin
            r_req0_rvalid <= r_tag_v[RD_LAT] & ~r_tag_id[RD_LAT];
            r_req1_rvalid <= r_tag_v[RD_LAT] &  r_tag_id[RD_LAT];
            if (r_tag_v[RD_LAT] && !r_tag_id[RD_LAT]) begin
                r_req0_rdata <= i_sram_data;
            end else begin
                r_req0_rdata <= r_req0_rdata;
            end
            if (r_tag_v[RD_LAT] && r_tag_id[RD_LAT]) begin
                r_req1_rdata <= i_sram_data;
            end else begin
                r_req1_rdata <= r_req1_rdata;
            end
        end
    end

    assign o_req0_ready  = w_gnt0;
    assign o_req1_ready  = w_gnt1;
    assign o_req0_rvalid = r_req0_rvalid;
    assign o_req0_rdata  = r_req0_rdata;
    assign o_req1_rvalid = r_req1_rvalid;
    assign o_req1_rdata  = r_req1_rdata;
    assign o_sram_cen    = r_sram_cen;
    assign o_sram_wen    = r_sram_wen;
    assign o_sram_oen    = r_sram_oen;
    assign o_sram_addr   = r_sram_addr;
    assign o_sram_data   = r_sram_data;

endmodule

// File: tb/tb_spsram_arbiter.sv
// Testbench for spsram_arbiter: directed scenarios plus a random mix, checked
// by a scoreboard fed from a word-level memory/fairness model.
module tb_spsram_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req0_valid = 1'b0, i_req0_we = 1'b0;
    logic [AW-1:0] i_req0_addr = '0;
    logic [DW-1:0] i_req0_wdata = '0;
    logic          i_req1_valid = 1'b0, i_req1_we = 1'b0;
    logic [AW-1:0] i_req1_addr = '0;
    logic [DW-1:0] i_req1_wdata = '0;
    logic          o_req0_ready, o_req0_rvalid, o_req1_ready, o_req1_rvalid;
    logic [DW-1:0] o_req0_rdata, o_req1_rdata;
    logic          o_sram_cen, o_sram_wen, o_sram_oen;
    logic [AW-1:0] o_sram_addr;
    logic [DW-1:0] o_sram_data;
    logic [DW-1:0] sram_q;

    spsram_arbiter #(.DW(DW), .AW(AW), .RD_LAT(LAT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready), .i_req0_we(i_req0_we),
        .i_req0_addr(i_req0_addr), .i_req0_wdata(i_req0_wdata),
        .o_req0_rvalid(o_req0_rvalid), .o_req0_rdata(o_req0_rdata),
        .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready), .i_req1_we(i_req1_we),
        .i_req1_addr(i_req1_addr), .i_req1_wdata(i_req1_wdata),
        .o_req1_rvalid(o_req1_rvalid), .o_req1_rdata(o_req1_rdata),
        .o_sram_cen(o_sram_cen), .o_sram_wen(o_sram_wen), .o_sram_oen(o_sram_oen),
        .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data), .i_sram_data(sram_q)
    );

    always #5 clk = ~clk;

    // Single-port SRAM with one cycle of read latency.
    logic [DW-1:0] sram_mem [32];
    always @(posedge clk) begin
        if (o_sram_cen && o_sram_wen) sram_mem[o_sram_addr] <= o_sram_data;
        if (o_sram_cen && o_sram_oen) sram_q <= sram_mem[o_sram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } drv_t;
    typedef struct { int cyc; bit rst; logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
    typedef struct { int cyc; logic [DW-1:0] data; } rd_t;

    drv_t q0[$], q1[$];
    cmd_t cmd_q[$];
    rd_t  rd0_q[$], rd1_q[$];
    int   grant_log[$];

    logic [DW-1:0] ref_mem [32];
    bit            ref_prio = 1'b0;
    logic [DW-1:0] ref_held_data = '0;
    logic [AW-1:0] mon_addr = '0;
    logic [DW-1:0] mon_data = '0, mon_rdata0 = '0, mon_rdata1 = '0;
    int checks = 0, errors = 0, rv0_cnt = 0, rv1_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: fairness rule + word memory updated in accept order.
    task automatic model_step();
        logic [1:0] exp_g;
        int win;
        cmd_t c;
        rd_t r;
        if (rst) begin
            chk("ready_in_reset", {o_req1_ready, o_req0_ready}, 2'b00);
            cmd_q.delete(); rd0_q.delete(); rd1_q.delete();
            c = '{cyc + 1, 1'b1, 1'b0, '0, '0};
            cmd_q.push_back(c);
            ref_prio = 1'b0;
            ref_held_data = '0;
        end else begin
            if (i_req0_valid && i_req1_valid) exp_g = ref_prio ? 2'b10 : 2'b01;
            else exp_g = {i_req1_valid, i_req0_valid};
            chk("ready", {o_req1_ready, o_req0_ready}, exp_g);
            if (exp_g != 2'b00) begin
                win = exp_g[1] ? 1 : 0;
                grant_log.push_back(win);
                c.cyc  = cyc + 1;
                c.rst  = 1'b0;
                c.we   = win ? i_req1_we : i_req0_we;
                c.addr = win ? i_req1_addr : i_req0_addr;
                if (c.we) begin
                    c.data = win ? i_req1_wdata : i_req0_wdata;
                    ref_held_data = c.data;
                    ref_mem[c.addr] = c.data;
                end else begin
                    c.data = ref_held_data;
                    r = '{cyc + 2 + LAT, ref_mem[c.addr]};
                    if (win == 1) rd1_q.push_back(r);
                    else rd0_q.push_back(r);
                end
                cmd_q.push_back(c);
                ref_prio = (win == 0);
            end
        end
    endtask

    // Monitor: compares SRAM port and read returns against due scoreboard entries.
    task automatic mon_step();
        cmd_t c;
        rd_t  r;
        bit   due0, due1;
        if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) begin
            c = cmd_q.pop_front();
            if (c.rst) begin
                chk("sram_ctl_after_reset", {o_sram_cen, o_sram_wen, o_sram_oen}, 3'b000);
                mon_addr = '0; mon_data = '0; mon_rdata0 = '0; mon_rdata1 = '0;
            end else begin
                chk("sram_ctl", {o_sram_cen, o_sram_wen, o_sram_oen}, {1'b1, c.we, ~c.we});
                mon_addr = c.addr;
                mon_data = c.data;
            end
        end else begin
            chk("sram_idle", {o_sram_cen, o_sram_wen, o_sram_oen}, 3'b000);
        end
        chk("sram_addr", o_sram_addr, mon_addr);
        chk("sram_data", o_sram_data, mon_data);
        due0 = rd0_q.size() > 0 && rd0_q[0].cyc == cyc;
        due1 = rd1_q.size() > 0 && rd1_q[0].cyc == cyc;
        chk("rvalid0", o_req0_rvalid, due0);
        chk("rvalid1", o_req1_rvalid, due1);
        if (due0) begin r = rd0_q.pop_front(); mon_rdata0 = r.data; end
        if (due1) begin r = rd1_q.pop_front(); mon_rdata1 = r.data; end
        if (o_req0_rvalid) rv0_cnt++;
        if (o_req1_rvalid) rv1_cnt++;
        chk("rdata0", o_req0_rdata, mon_rdata0);
        chk("rdata1", o_req1_rdata, mon_rdata1);
    endtask

    always @(negedge clk) mon_step();
    always @(negedge clk) begin
        #1;
        model_step();
    end

    // Drive both requester queues; valid is held until ready, optional random gaps.
    task automatic run(input bit gaps, input int budget);
        bit a0 = 1'b0, a1 = 1'b0, g0, g1;
        int n = 0;
        drv_t d;
        while ((q0.size() > 0 || a0 || q1.size() > 0 || a1) && n < budget) begin
            if (!a0 && q0.size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
                d = q0.pop_front();
                i_req0_valid = 1'b1; i_req0_we = d.we; i_req0_addr = d.addr; i_req0_wdata = d.data;
                a0 = 1'b1;
            end else if (!a0) begin
                i_req0_valid = 1'b0;
            end
            if (!a1 && q1.size() > 0 && !(gaps && $urandom_range(0, 3) == 0)) begin
                d = q1.pop_front();
                i_req1_valid = 1'b1; i_req1_we = d.we; i_req1_addr = d.addr; i_req1_wdata = d.data;
                a1 = 1'b1;
            end else if (!a1) begin
                i_req1_valid = 1'b0;
            end
            @(negedge clk);
            g0 = a0 && o_req0_ready;
            g1 = a1 && o_req1_ready;
            @(posedge clk); #1;
            if (g0) a0 = 1'b0;
            if (g1) a1 = 1'b0;
            n++;
        end
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        chk("run_completed_in_budget", (n < budget), 1'b1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) begin @(posedge clk); #1; end
        rst = 1'b0;
    endtask

    task automatic drain(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base0, base1;
        drv_t d;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: req0 writes addr i = i, back to back.
        grant_log.delete();
        for (int i = 0; i < 32; i++) begin d = '{1'b1, AW'(i), DW'(i)}; q0.push_back(d); end
        run(1'b0, 200);
        chk("t1_grant_count", grant_log.size(), 32);

        // 2: req1 reads everything back.
        for (int i = 0; i < 32; i++) begin d = '{1'b0, AW'(i), '0}; q1.push_back(d); end
        run(1'b0, 200);
        drain(6);
        chk("t2_rvalid1_count", rv1_cnt, 32);
        chk("t2_rvalid0_count", rv0_cnt, 0);

        // 3: contested writes from reset alternate 0,1,0,1...
        do_reset(2);
        grant_log.delete();
        for (int i = 0; i < 16; i++) begin
            d = '{1'b1, AW'(i), 32'hA000_0000 + DW'(i)};      q0.push_back(d);
            d = '{1'b1, AW'(16 + i), 32'hB000_0000 + DW'(i)}; q1.push_back(d);
        end
        run(1'b0, 200);
        chk("t3_grant_count", grant_log.size(), 32);
        for (int k = 0; k < grant_log.size(); k++) chk("t3_alternate", grant_log[k], k % 2);

        // 4: same-cycle write and read of addr 7.
        do_reset(1);
        grant_log.delete();
        d = '{1'b1, 5'd7, 32'h1234_5678}; q0.push_back(d);
        d = '{1'b0, 5'd7, '0};            q1.push_back(d);
        run(1'b0, 50);
        drain(6);
        chk("t4_first_grant", grant_log[0], 0);
        chk("t4_rdata1", o_req1_rdata, 32'h1234_5678);

        // 5: interleaved reads of addr 3 (req0) and addr 4 (req1).
        d = '{1'b1, 5'd3, 32'd3}; q0.push_back(d);
        d = '{1'b1, 5'd4, 32'd4}; q0.push_back(d);
        run(1'b0, 50);
        base0 = rv0_cnt; base1 = rv1_cnt;
        for (int i = 0; i < 4; i++) begin
            d = '{1'b0, 5'd3, '0}; q0.push_back(d);
            d = '{1'b0, 5'd4, '0}; q1.push_back(d);
        end
        run(1'b0, 50);
        drain(6);
        chk("t5_rv0_count", rv0_cnt - base0, 4);
        chk("t5_rv1_count", rv1_cnt - base1, 4);
        chk("t5_rdata0", o_req0_rdata, 32'd3);
        chk("t5_rdata1", o_req1_rdata, 32'd4);

        // 6: reset with two reads in flight.
        base0 = rv0_cnt; base1 = rv1_cnt;
        d = '{1'b0, 5'd10, '0}; q0.push_back(d);
        d = '{1'b0, 5'd11, '0}; q1.push_back(d);
        run(1'b0, 50);
        do_reset(1);
        @(negedge clk);
        chk("t6_ctl_after_reset", {o_sram_cen, o_sram_wen, o_sram_oen}, 3'b000);
        @(posedge clk); #1;
        grant_log.delete();
        d = '{1'b1, 5'd20, 32'hC0DE_0020}; q0.push_back(d);
        d = '{1'b1, 5'd21, 32'hC0DE_0021}; q1.push_back(d);
        run(1'b0, 50);
        drain(6);
        chk("t6_first_grant", grant_log[0], 0);
        chk("t6_no_rvalid0", rv0_cnt - base0, 0);
        chk("t6_no_rvalid1", rv1_cnt - base1, 0);

        // 7: random mix with gaps.
        for (int i = 0; i < 40; i++) begin
            d = '{1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom)}; q0.push_back(d);
            d = '{1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom)}; q1.push_back(d);
        end
        run(1'b1, 2000);
        drain(8);

        chk("end_cmd_q_empty", cmd_q.size(), 0);
        chk("end_rd0_q_empty", rd0_q.size(), 0);
        chk("end_rd1_q_empty", rd1_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
